// File: rtl/uart_fifo_pkg.sv
// rtl/uart_fifo_pkg.sv - shared defaults and helpers for the UART FIFO
package uart_fifo_pkg;

    localparam int UART_FIFO_DATA_W_DEF = 8;
    localparam int UART_FIFO_DEPTH_DEF  = 4;
    localparam int DROP_CNT_W           = 16;

    // Occupancy needs one bit more than the pointers so that "full" is representable.
    function automatic int level_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/uart_fifo_mem.sv
// rtl/uart_fifo_mem.sv - DEPTH x DATA_W register file, sync write, registered read
module uart_fifo_mem
    import uart_fifo_pkg::*;
#(
    parameter int DATA_W = UART_FIFO_DATA_W_DEF,
    parameter int DEPTH  = UART_FIFO_DEPTH_DEF
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     wr_en,
    input  logic [$clog2(DEPTH)-1:0] wr_addr,
    input  logic [DATA_W-1:0]        wr_data,
    input  logic                     rd_en,
    input  logic [$clog2(DEPTH)-1:0] rd_addr,
    output logic [DATA_W-1:0]        rd_data
);

    logic [DATA_W-1:0] mem [DEPTH];

    // Storage is deliberately left unreset; only the output register is cleared.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_data <= '0;
        end else if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/uart_fifo.sv
// rtl/uart_fifo.sv - UART ring-buffer FIFO; optional drop counter under UART_FIFO_DROP_CNT_EN
module uart_fifo
    import uart_fifo_pkg::*;
#(
    parameter int DATA_W   = UART_FIFO_DATA_W_DEF,
    parameter int DEPTH    = UART_FIFO_DEPTH_DEF,
    parameter int AF_LEVEL = DEPTH - 1
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      wr_en,
    input  logic [DATA_W-1:0]         wr_data,
    input  logic                      rd_en,
    output logic                      rd_ack,
    output logic [DATA_W-1:0]         rd_data,
    input  logic                      flush,
    input  logic                      clr_flags,
    output logic                      full,
    output logic                      empty,
    output logic                      almost_full,
    output logic [level_w(DEPTH)-1:0] level,
    output logic                      overflow,
    output logic                      underflow
`ifdef UART_FIFO_DROP_CNT_EN
    ,
    output logic [DROP_CNT_W-1:0]     drop_cnt
`endif
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = level_w(DEPTH);
    localparam logic [LW-1:0] DEPTH_C = LW'(DEPTH);
    localparam logic [LW-1:0] AF_C    = LW'(AF_LEVEL);

    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [LW-1:0] count;
    logic          rd_ok;
    logic          wr_ok;
    logic          drop;
    logic          refuse;

    // A full FIFO still takes a write when a read frees a slot in the same cycle.
    assign rd_ok  = !flush && rd_en && (count != '0);
    assign wr_ok  = !flush && wr_en && ((count != DEPTH_C) || rd_ok);
    assign drop   = !flush && wr_en && !wr_ok;
    assign refuse = !flush && rd_en && !rd_ok;

    assign full        = (count == DEPTH_C);
    assign empty       = (count == '0);
    assign almost_full = (count >= AF_C);
    assign level       = count;

    uart_fifo_mem #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_mem (
        .clk     (clk),
        .reset_n (reset_n),
        .wr_en   (wr_ok),
        .wr_addr (wr_ptr),
        .wr_data (wr_data),
        .rd_en   (rd_ok),
        .rd_addr (rd_ptr),
        .rd_data (rd_data)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            rd_ack    <= 1'b0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
`ifdef UART_FIFO_DROP_CNT_EN
            drop_cnt  <= '0;
`endif
        end else begin
            // A new drop or refusal wins over a simultaneous clear.
            overflow  <= (overflow && !clr_flags) || drop;
            underflow <= (underflow && !clr_flags) || refuse;
`ifdef UART_FIFO_DROP_CNT_EN
            if (flush) begin
                drop_cnt <= '0;
            end else if (clr_flags) begin
                drop_cnt <= drop ? DROP_CNT_W'(1) : '0;
            end else if (drop && (drop_cnt != '1)) begin
                drop_cnt <= drop_cnt + DROP_CNT_W'(1);
            end
`endif
            if (flush) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
                count  <= '0;
                rd_ack <= 1'b0;
            end else begin
                rd_ack <= rd_ok;
                if (rd_ok) begin
                    rd_ptr <= rd_ptr + AW'(1);
                end
                if (wr_ok) begin
                    wr_ptr <= wr_ptr + AW'(1);
                end
                if (wr_ok && !rd_ok) begin
                    count <= count + LW'(1);
                end else if (rd_ok && !wr_ok) begin
                    count <= count - LW'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_uart_fifo.sv
// tb/tb_uart_fifo.sv - directed + random check of uart_fifo against a queue model
module tb_uart_fifo;

    localparam int DEPTH = 4;
    localparam int AF    = 3;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       wr_en = 1'b0;
    logic [7:0] wr_data = 8'h00;
    logic       rd_en = 1'b0;
    logic       flush = 1'b0;
    logic       clr_flags = 1'b0;
    logic       rd_ack;
    logic [7:0] rd_data;
    logic       full;
    logic       empty;
    logic       almost_full;
    logic [2:0] level;
    logic       overflow;
    logic       underflow;
`ifdef UART_FIFO_DROP_CNT_EN
    logic [15:0] drop_cnt;
`endif

    int errors = 0;
    int checks = 0;

    logic [7:0]  q[$];
    logic [7:0]  m_rdat = 8'h00;
    logic        m_ack = 1'b0;
    logic        m_ov = 1'b0;
    logic        m_un = 1'b0;
    logic [15:0] m_dc = 16'h0;

    uart_fifo #(.DATA_W(8), .DEPTH(DEPTH), .AF_LEVEL(AF)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .wr_en       (wr_en),
        .wr_data     (wr_data),
        .rd_en       (rd_en),
        .rd_ack      (rd_ack),
        .rd_data     (rd_data),
        .flush       (flush),
        .clr_flags   (clr_flags),
        .full        (full),
        .empty       (empty),
        .almost_full (almost_full),
        .level       (level),
        .overflow    (overflow),
        .underflow   (underflow)
`ifdef UART_FIFO_DROP_CNT_EN
        ,
        .drop_cnt    (drop_cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        chk("rd_ack", 32'(rd_ack), 32'(m_ack));
        chk("rd_data", 32'(rd_data), 32'(m_rdat));
        chk("level", 32'(level), 32'(q.size()));
        chk("full", 32'(full), 32'(q.size() == DEPTH));
        chk("empty", 32'(empty), 32'(q.size() == 0));
        chk("almost_full", 32'(almost_full), 32'(q.size() >= AF));
        chk("overflow", 32'(overflow), 32'(m_ov));
        chk("underflow", 32'(underflow), 32'(m_un));
`ifdef UART_FIFO_DROP_CNT_EN
        chk("drop_cnt", 32'(drop_cnt), 32'(m_dc));
`endif
    endtask

    task automatic model_reset();
        q.delete();
        m_rdat = 8'h00;
        m_ack = 1'b0;
        m_ov = 1'b0;
        m_un = 1'b0;
        m_dc = 16'h0;
    endtask

    // One clock: drive inputs, advance the model by the behavioural rules, compare after the edge.
    task automatic step(input logic w, input logic [7:0] d, input logic r,
                        input logic f, input logic c);
        bit rd_ok;
        bit wr_ok;
        bit drop;
        wr_en = w;
        wr_data = d;
        rd_en = r;
        flush = f;
        clr_flags = c;
        drop = 1'b0;
        if (f) begin
            q.delete();
            m_ack = 1'b0;
            if (c) begin
                m_ov = 1'b0;
                m_un = 1'b0;
            end
            m_dc = 16'h0;
        end else begin
            rd_ok = r && (q.size() > 0);
            wr_ok = w && ((q.size() < DEPTH) || rd_ok);
            drop = w && !wr_ok;
            m_ov = (m_ov && !c) || drop;
            m_un = (m_un && !c) || (r && !rd_ok);
            if (c) m_dc = drop ? 16'd1 : 16'd0;
            else if (drop && m_dc != 16'hFFFF) m_dc = m_dc + 16'd1;
            m_ack = rd_ok;
            if (rd_ok) m_rdat = q.pop_front();
            if (wr_ok) q.push_back(d);
        end
        @(posedge clk);
        #1;
        check_all();
    endtask

    task automatic wr(input logic [7:0] d);
        step(1'b1, d, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic rd();
        step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    endtask

    initial begin
        #3;
        check_all();
        @(negedge clk);
        reset_n = 1'b1;

        // Basic fill and drain
        wr(8'h11); wr(8'h22); wr(8'h33); wr(8'h44);
        chk("full_after_4", 32'(full), 32'd1);
        rd(); chk("first_read", 32'(rd_data), 32'h11);
        rd(); rd(); rd();
        chk("last_read", 32'(rd_data), 32'h44);
        chk("empty_after_4", 32'(empty), 32'd1);

        // Dropped write on full, then clear flags
        wr(8'h11); wr(8'h22); wr(8'h33); wr(8'h44);
        wr(8'h55);
        chk("ovf_set", 32'(overflow), 32'd1);
        chk("ovf_level", 32'(level), 32'd4);
        step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        chk("ovf_clr", 32'(overflow), 32'd0);

        // Simultaneous read and write on full
        step(1'b1, 8'h66, 1'b1, 1'b0, 1'b0);
        chk("full_rw_data", 32'(rd_data), 32'h11);
        chk("full_rw_level", 32'(level), 32'd4);
        rd(); rd(); rd(); rd();
        chk("full_rw_tail", 32'(rd_data), 32'h66);

        // Simultaneous read and write on empty: no bypass
        step(1'b1, 8'h77, 1'b1, 1'b0, 1'b0);
        chk("empty_rw_ack", 32'(rd_ack), 32'd0);
        chk("empty_rw_unf", 32'(underflow), 32'd1);
        rd();
        chk("empty_rw_data", 32'(rd_data), 32'h77);
        step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);

        // Pointer wrap with single-entry traffic
        for (int i = 0; i < 10; i++) begin
            wr(8'(i));
            rd();
        end

        // Almost-full threshold, then flush at level 3
        wr(8'hA1); wr(8'hA2);
        chk("af_at_2", 32'(almost_full), 32'd0);
        wr(8'hA3);
        chk("af_at_3", 32'(almost_full), 32'd1);
        step(1'b1, 8'hEE, 1'b1, 1'b1, 1'b0);
        chk("flush_empty", 32'(empty), 32'd1);
        chk("flush_rd_data", 32'(rd_data), 32'h09);

        // Drop counter
        wr(8'h01); wr(8'h02); wr(8'h03); wr(8'h04);
        wr(8'h05); wr(8'h06); wr(8'h07);
`ifdef UART_FIFO_DROP_CNT_EN
        chk("drop_cnt_3", 32'(drop_cnt), 32'd3);
`endif
        step(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);

        // Reset mid-stream
        wr(8'hB1); wr(8'hB2); rd();
        #2;
        reset_n = 1'b0;
        #1;
        model_reset();
        check_all();
        chk("rst_rd_data", 32'(rd_data), 32'h0);
        @(negedge clk);
        reset_n = 1'b1;
        rd();
        chk("post_rst_unf", 32'(underflow), 32'd1);

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            step(1'($urandom_range(0, 1)), 8'($urandom), 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 31) == 0), 1'($urandom_range(0, 15) == 0));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/uart_fifo.md
Name: uart_fifo

Overview:
- Parametrised UART byte/word FIFO; next generation of the UART receive/transmit ring buffer, sitting between the UART shifter and the CPU-side IO register block.
- Adds configurable width/depth, same-cycle read+write, explicit full/empty/level outputs, almost-full threshold, synchronous flush and sticky overflow/underflow flags.

Parameters:
DATA_W, 8, data word width in bits (1..32)
DEPTH, 4, number of entries; power of two, 2..256
AF_LEVEL, DEPTH-1, almost_full asserts when level >= AF_LEVEL (1..DEPTH)

Ports:
clk  in  1  global clock, rising edge
reset_n  in  1  asynchronous, active-low reset
wr_en  in  1  write request, one word per cycle
wr_data  in  DATA_W  word to write
rd_en  in  1  read request
rd_ack  out  1  one-cycle pulse: rd_data updated by an accepted read
rd_data  out  DATA_W  registered read data, held until the next accepted read
flush  in  1  synchronous clear of contents
clr_flags  in  1  clears overflow/underflow
full  out  1  level == DEPTH
empty  out  1  level == 0
almost_full  out  1  level >= AF_LEVEL
level  out  $clog2(DEPTH)+1  current occupancy
overflow  out  1  sticky: a write was dropped
underflow  out  1  sticky: a read was refused

Behaviour:
- State: mem[DEPTH], wr_ptr/rd_ptr ($clog2(DEPTH) bits, wrap modulo DEPTH by natural overflow), count ($clog2(DEPTH)+1 bits). full/empty/almost_full/level decode combinationally from count only.
- Reset (reset_n low, async): pointers=0, count=0, rd_ack=0, rd_data=0, overflow=0, underflow=0. mem not reset. Reset mid-operation discards all contents; first edge after release behaves as empty FIFO.
- Accept rules, evaluated per rising edge on current count:
  - rd_ok = rd_en && count != 0.
  - wr_ok = wr_en && (count != DEPTH || rd_ok).
- rd_ok: rd_data <= mem[rd_ptr]; rd_ack <= 1; rd_ptr++. Else rd_ack <= 0 (rd_data holds).
- wr_ok: mem[wr_ptr] <= wr_data; wr_ptr++.
- count: +1 if wr_ok only, -1 if rd_ok only, unchanged if both or neither.
- Latency: word written at edge N readable at edge N+1 (rd_ack at N+1); no write-to-read bypass when empty (rd_en && wr_en on empty -> write stored, read refused).
- Full + rd_en + wr_en: both accepted, count stays DEPTH.
- Dropped write (wr_en && !wr_ok): overflow <= 1; contents unchanged.
- Refused read (rd_en && !rd_ok): underflow <= 1; rd_ack <= 0.
- flush: highest priority after reset; pointers=0, count=0, rd_ack<=0, rd_data holds; wr_en/rd_en ignored that cycle, no flag set.
- clr_flags: clears overflow/underflow; a new drop/refusal in the same cycle wins (flag stays 1).
- No state machine beyond pointer/count registers; single always block for control, separate storage.

Optional Feature:
- Macro UART_FIFO_DROP_CNT_EN.
- Defined: extra output drop_cnt [15:0]; increments on each dropped write, saturates at 16'hFFFF, cleared by reset, flush or clr_flags (clr_flags with a simultaneous drop -> 1).
- Undefined: port and counter absent; all other behaviour identical.

Decomposition:
- Package uart_fifo_pkg: default constants (UART_FIFO_DATA_W_DEF=8, UART_FIFO_DEPTH_DEF=4), DROP_CNT_W=16, function computing level width from DEPTH.
- Sub-module uart_fifo_mem: DEPTH x DATA_W register file, one synchronous write port, one synchronous registered read port; control logic (pointers, count, flags) stays in uart_fifo.

Test Plan:
- DATA_W=8, DEPTH=4: write 0x11,0x22,0x33,0x44 then 4 reads -> rd_ack each cycle after request, rd_data 0x11..0x44 in order, full=1 after 4th write, empty=1 after 4th read, level 4->0.
- Full FIFO, write 0x55 alone -> dropped, overflow=1, level=4; next reads still return 0x11..0x44; clr_flags -> overflow=0.
- Full FIFO, rd_en+wr_en 0x66 same cycle -> rd_data=0x11, rd_ack=1, level stays 4; drain yields 0x22,0x33,0x44,0x66.
- Empty FIFO, rd_en+wr_en 0x77 -> rd_ack=0, underflow=1, level=1; next read returns 0x77.
- Pointer wrap: 10 interleaved single write/read pairs (0x00..0x09) -> each read returns matching value, level never >1; AF_LEVEL=3: almost_full asserts exactly at level 3.
- Level 3, assert flush then reset_n low mid-stream -> flush: level=0, empty=1, rd_data unchanged; reset: rd_data=0, flags=0; with UART_FIFO_DROP_CNT_EN, 3 dropped writes -> drop_cnt=3, cleared by flush.
